// File: rtl/ps2_pkg.sv
// Shared types and defaults for the PS/2 device-to-host receiver.
// Holds the deframer state encoding and the default parameter values.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int FRAME_BITS = 8;

  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_FILTER_LEN     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through scan-code FIFO: head entry is always on rdata.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: pin sync, clock filter, frame FSM, FWFT FIFO, sticky errors.
// Define PS2_RX_TIMEOUT_EN to build the frame watchdog; otherwise timeout_err is tied 0.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          nextdata_n,
  input  logic                          err_clr,
  output logic [7:0]                    data,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          timeout_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int BCW = $clog2(FRAME_BITS);

  logic           clk_s1, clk_s2, dat_s1, dat_s2;
  logic           clk_filt, filt_d, fall;
  logic [FCW-1:0] filt_cnt;

  rx_state_t             state, state_nx;
  logic [BCW-1:0]        bit_cnt, bit_cnt_nx;
  logic [FRAME_BITS-1:0] shreg, shreg_nx;
  logic                  par_bit, par_nx;
  logic                  push, perr_set, ferr_set, ovf_set, tmo_hit;
  logic                  fifo_full, fifo_empty, pop_ok;

  // Everything idles high so releasing reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      filt_d   <= 1'b1;
      fall     <= 1'b0;
      filt_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      filt_d <= clk_filt;
      fall   <= filt_d & ~clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      par_bit <= par_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par_bit;
    push       = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_nx   = DATA;
            bit_cnt_nx = '0;
          end
        end
        DATA: begin
          shreg_nx = {dat_s2, shreg[FRAME_BITS-1:1]};
          if (bit_cnt == BCW'(FRAME_BITS - 1)) state_nx = PARITY;
          else bit_cnt_nx = bit_cnt + BCW'(1);
        end
        PARITY: begin
          par_nx   = dat_s2;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (!dat_s2)                   ferr_set = 1'b1;
          else if (!(^{shreg, par_bit})) perr_set = 1'b1;
          else                           push     = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nx = IDLE;
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;

  assign tmo_hit = (state != IDLE) && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE || fall || tmo_hit) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + WDW'(1);
      timeout_err <= (tmo_hit & ~fall) | (timeout_err & ~err_clr);
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign pop_ok  = ~nextdata_n & ready;
  assign ovf_set = push & fifo_full & ~pop_ok;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overflow   <= ovf_set  | (overflow   & ~err_clr);
      parity_err <= perr_set | (parity_err & ~err_clr);
      frame_err  <= ferr_set | (frame_err  & ~err_clr);
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_BITS)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .wdata (shreg),
    .pop   (~nextdata_n),
    .rdata (data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign ready = ~fifo_empty;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed scenarios plus randomized frames
// checked against a queue-based model of the receive/error rules.
module tb_ps2_receiver;

  localparam int DEPTH = 8;
  localparam int FL    = 4;
  localparam int TMO   = 100;
  localparam int HALF  = 10;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic [3:0] level;
  logic       overflow, parity_err, frame_err, timeout_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  bit m_ovf = 0, m_perr = 0, m_ferr = 0;

  ps2_receiver #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .nextdata_n  (nextdata_n),
    .err_clr     (err_clr),
    .data        (data),
    .ready       (ready),
    .level       (level),
    .overflow    (overflow),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  // One PS/2 bit: clock high with new data, then clock falls; returns just after the fall.
  task automatic pin_fall(input logic b);
    repeat (HALF) @(posedge clk);
    #1; ps2_data = b; ps2_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    #1; ps2_clk = 1'b0;
  endtask

  task automatic pin_idle();
    repeat (HALF) @(posedge clk);
    #1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit pflip, input bit stopv);
    logic par;
    par = ~(^b) ^ pflip;
    pin_fall(1'b0);
    for (int i = 0; i < 8; i++) pin_fall(b[i]);
    pin_fall(par);
    pin_fall(stopv);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit pflip, input bit stopv, input bit pop_w);
    if (pop_w && q.size() > 0) void'(q.pop_front());
    if (!stopv)                m_ferr = 1;
    else if (pflip)            m_perr = 1;
    else if (q.size() < DEPTH) q.push_back(b);
    else                       m_ovf = 1;
  endtask

  // Full frame; with pop_w the pop is presented on the exact edge the byte is written.
  task automatic send_frame(input logic [7:0] b, input bit pflip, input bit stopv, input bit pop_w);
    send_bits(b, pflip, stopv);
    repeat (7) @(posedge clk);
    #1; if (pop_w) nextdata_n = 1'b0;
    @(posedge clk);
    #1; nextdata_n = 1'b1;
    model_frame(b, pflip, stopv, pop_w);
    pin_idle();
  endtask

  task automatic pop_one();
    nextdata_n = 1'b0;
    @(posedge clk);
    #1; nextdata_n = 1'b1;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(posedge clk);
    #1; err_clr = 1'b0;
    m_ovf = 0; m_perr = 0; m_ferr = 0;
  endtask

  task automatic test_reset();
    #2; clrn = 1'b0;
    #6;
    tests++;
    if ({ready, level} !== 5'd0) begin
      fails++; $display("FAIL reset_fifo: ready=%b level=%0d, want 0/0", ready, level);
    end
    tests++;
    if ({overflow, parity_err, frame_err, timeout_err} !== 4'b0) begin
      fails++; $display("FAIL reset_flags: ovf/par/frm/tmo=%b%b%b%b, want 0000",
                        overflow, parity_err, frame_err, timeout_err);
    end
    @(negedge clk); clrn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [7:0] b;
    b = 8'h1C;
    send_bits(b, 1'b0, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    tests++;
    if (ready !== 1'b0) begin
      fails++; $display("FAIL latency_early: ready=%b at cycle 7, want 0", ready);
    end
    @(posedge clk);
    #1;
    model_frame(b, 1'b0, 1'b1, 1'b0);
    tests++;
    if (ready !== 1'b1 || data !== 8'h1C || level !== 4'd1) begin
      fails++; $display("FAIL latency_8: ready=%b data=%h level=%0d, want 1/1c/1", ready, data, level);
    end
    pin_idle();
    pop_one();
    tests++;
    if (ready !== 1'b0 || level !== 4'd0) begin
      fails++; $display("FAIL single_pop: ready=%b level=%0d, want 0/0", ready, level);
    end
  endtask

  task automatic test_parity();
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    tests++;
    if (parity_err !== 1'b1 || frame_err !== 1'b0 || level !== 4'd0) begin
      fails++; $display("FAIL parity_set: par=%b frm=%b level=%0d, want 1/0/0", parity_err, frame_err, level);
    end
    clear_errs();
    tests++;
    if (parity_err !== 1'b0) begin
      fails++; $display("FAIL parity_clr: par=%b, want 0", parity_err);
    end
  endtask

  task automatic test_frame();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    tests++;
    if (frame_err !== 1'b1 || parity_err !== 1'b0 || level !== 4'd0 || ready !== 1'b0) begin
      fails++; $display("FAIL frame_err: frm=%b par=%b level=%0d ready=%b, want 1/0/0/0",
                        frame_err, parity_err, level, ready);
    end
    clear_errs();
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b1, 1'b0);
    tests++;
    if (level !== 4'd8 || overflow !== 1'b1) begin
      fails++; $display("FAIL overflow: level=%0d ovf=%b, want 8/1", level, overflow);
    end
    for (int k = 1; k <= 8; k++) begin
      tests++;
      if (data !== 8'(k)) begin
        fails++; $display("FAIL ovf_order: got %h, want %h", data, 8'(k));
      end
      pop_one();
    end
    tests++;
    if (ready !== 1'b0 || level !== 4'd0) begin
      fails++; $display("FAIL ovf_drain: ready=%b level=%0d, want 0/0", ready, level);
    end
    clear_errs();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < DEPTH; k++) send_frame(8'h40 + 8'(k), 1'b0, 1'b1, 1'b0);
    send_frame(8'h77, 1'b0, 1'b1, 1'b1);
    tests++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      fails++; $display("FAIL full_poppush: level=%0d ovf=%b, want 8/0", level, overflow);
    end
    while (q.size() > 0) begin
      tests++;
      if (data !== q[0]) begin
        fails++; $display("FAIL full_order: got %h, want %h", data, q[0]);
      end
      pop_one();
    end
    send_frame(8'hA1, 1'b0, 1'b1, 1'b0);
    send_frame(8'hA2, 1'b0, 1'b1, 1'b1);
    tests++;
    if (ready !== 1'b1 || level !== 4'd1 || data !== 8'hA2) begin
      fails++; $display("FAIL lvl1_poppush: ready=%b level=%0d data=%h, want 1/1/a2", ready, level, data);
    end
    pop_one();
  endtask

  task automatic test_glitch();
    for (int g = 0; g < 6; g++) begin
      int w;
      w = int'($urandom_range(1, FL - 1));
      @(posedge clk);
      #1; ps2_clk = 1'b0; ps2_data = g[0];
      repeat (w) @(posedge clk);
      #1; ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (12) @(posedge clk);
      #1;
    end
    tests++;
    if ({ready, overflow, parity_err, frame_err, timeout_err} !== 5'b0) begin
      fails++; $display("FAIL glitch_quiet: ready/ovf/par/frm/tmo=%b%b%b%b%b, want 00000",
                        ready, overflow, parity_err, frame_err, timeout_err);
    end
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    tests++;
    if (ready !== 1'b1 || data !== 8'h12 || level !== 4'd1 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      fails++; $display("FAIL glitch_frame: ready=%b data=%h level=%0d par=%b frm=%b, want 1/12/1/0/0",
                        ready, data, level, parity_err, frame_err);
    end
    pop_one();
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      int r;
      bit pflip, stopv, pop_w;
      b = 8'($urandom);
      r = int'($urandom_range(0, 9));
      pflip = (r < 2);
      stopv = (r != 2);
      pop_w = ($urandom_range(0, 3) == 0);
      if (pop_w && q.size() > 0) begin
        tests++;
        if (data !== q[0]) begin
          fails++; $display("FAIL rand_head: got %h, want %h", data, q[0]);
        end
      end
      send_frame(b, pflip, stopv, pop_w);
      tests++;
      if (level !== 4'(q.size()) || overflow !== m_ovf || parity_err !== m_perr || frame_err !== m_ferr) begin
        fails++; $display("FAIL rand_state: level=%0d ovf=%b par=%b frm=%b, want %0d/%b/%b/%b",
                          level, overflow, parity_err, frame_err, q.size(), m_ovf, m_perr, m_ferr);
      end
      if ($urandom_range(0, 2) == 0 && q.size() > 0) begin
        tests++;
        if (data !== q[0]) begin
          fails++; $display("FAIL rand_pop: got %h, want %h", data, q[0]);
        end
        pop_one();
      end
    end
    while (q.size() > 0) begin
      tests++;
      if (data !== q[0]) begin
        fails++; $display("FAIL rand_drain: got %h, want %h", data, q[0]);
      end
      pop_one();
    end
    clear_errs();
  endtask

`ifdef PS2_RX_TIMEOUT_EN
  task automatic test_timeout();
    pin_fall(1'b0);
    pin_fall(1'b0);
    pin_fall(1'b0);
    pin_fall(1'b1);
    for (int i = 1; i <= 108; i++) begin
      @(posedge clk);
      #1;
      if (i == 12) ps2_clk = 1'b1;
      if (i == 107) begin
        tests++;
        if (timeout_err !== 1'b0) begin
          fails++; $display("FAIL timeout_early: tmo=%b one cycle before limit, want 0", timeout_err);
        end
      end
    end
    tests++;
    if (timeout_err !== 1'b1 || level !== 4'd0) begin
      fails++; $display("FAIL timeout_set: tmo=%b level=%0d, want 1/0", timeout_err, level);
    end
    pin_idle();
    send_frame(8'h34, 1'b0, 1'b1, 1'b0);
    tests++;
    if (ready !== 1'b1 || data !== 8'h34 || level !== 4'd1 || timeout_err !== 1'b1) begin
      fails++; $display("FAIL timeout_next: ready=%b data=%h level=%0d tmo=%b, want 1/34/1/1",
                        ready, data, level, timeout_err);
    end
    clear_errs();
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++; $display("FAIL timeout_clr: tmo=%b, want 0", timeout_err);
    end
    pop_one();
  endtask
`else
  task automatic test_stall();
    logic [7:0] b;
    b = 8'h34;
    pin_fall(1'b0);
    for (int i = 0; i < 3; i++) pin_fall(b[i]);
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (i == 12) ps2_clk = 1'b1;
    end
    tests++;
    if (timeout_err !== 1'b0 || level !== 4'd0) begin
      fails++; $display("FAIL stall_quiet: tmo=%b level=%0d, want 0/0", timeout_err, level);
    end
    for (int i = 3; i < 8; i++) pin_fall(b[i]);
    pin_fall(~(^b));
    pin_fall(1'b1);
    repeat (8) @(posedge clk);
    #1;
    model_frame(b, 1'b0, 1'b1, 1'b0);
    pin_idle();
    tests++;
    if (ready !== 1'b1 || data !== 8'h34 || level !== 4'd1) begin
      fails++; $display("FAIL stall_resume: ready=%b data=%h level=%0d, want 1/34/1", ready, data, level);
    end
    pop_one();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_frame();
    test_overflow();
    test_back_to_back();
    test_glitch();
    test_random();
`ifdef PS2_RX_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Parametrised PS/2 device-to-host receiver: next generation of the keyboard front-end in the peripheral subsystem. Filters and synchronises ps2_clk/ps2_data, deframes 11-bit frames through an explicit state machine, and buffers scan codes in a configurable-depth first-word-fall-through FIFO. Adds sticky error reporting (parity, framing, overflow, optional timeout) and a fill-level output for the bus-side register wrapper.

## Interface
- FIFO_DEPTH, 8: FIFO entries; power of two, ≥2.
- FILTER_LEN, 4: consecutive stable synchronised samples required before the filtered ps2_clk changes; ≥1.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge before an in-progress frame is aborted.
- clk  in  1  system clock; one clock domain.
- clrn  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin.
- ps2_data  in  1  raw PS/2 data pin.
- nextdata_n  in  1  active-low pop; honoured only while ready=1.
- err_clr  in  1  one-cycle pulse clearing all sticky error flags.
- data  out  8  head-of-FIFO scan code; valid only while ready=1.
- ready  out  1  FIFO non-empty.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: frame dropped because FIFO full.
- parity_err  out  1  sticky: odd-parity check failed.
- frame_err  out  1  sticky: stop bit sampled 0.
- timeout_err  out  1  sticky: frame aborted by watchdog.

## Operation
- Reset (clrn low, immediate): ready, level, overflow, parity_err, frame_err, timeout_err = 0; FIFO pointers 0; state IDLE; both 2-flop synchronisers and filtered clock = 1 (no false edge on release); data undefined.
- Filter: counter increments while synchronised ps2_clk ≠ filtered value, clears when equal; on reaching FILTER_LEN the filtered value takes the synchronised value. Filtered 1→0 produces one-cycle pulse fall; data bit is the synchronised ps2_data at that pulse.
- FSM on fall only: IDLE — bit 0 → DATA (bit 1 ignored as glitch, stay IDLE); DATA — shift LSB first, after 8th bit → PARITY; PARITY — capture → STOP; STOP — stop=1 and odd parity → push; parity bad → parity_err; stop=0 → frame_err (frame_err takes priority, no parity_err); always → IDLE.
- Push when full: byte dropped, overflow set, FIFO unchanged. Pop and push in same cycle while full: both accepted, level unchanged.
- Pop: nextdata_n=0 with ready=1 advances read pointer; ready=0 ignores nextdata_n. Pop+push with level=1: ready stays 1, data shows new byte.
- Pointers wrap modulo FIFO_DEPTH; level computed separately, 0..FIFO_DEPTH.
- Sticky flags: set event and err_clr in same cycle → flag ends 1.

## Timing
- Pin ps2_clk low first sampled at edge 1: sync out at edge 2, filtered low at edge 2+FILTER_LEN, fall high after edge 3+FILTER_LEN, FIFO write at edge 4+FILTER_LEN; ready/level update visible after that edge (FILTER_LEN=4 → 8 cycles from stop-bit fall).
- Pop: data/level/ready update the edge nextdata_n=0 is sampled; zero-latency FWFT read (data combinational from head entry).
- Watchdog: counter clears on each fall and in IDLE; reaching TIMEOUT_CYCLES outside IDLE → IDLE, timeout_err set the same edge.

## Configuration
- PS2_RX_TIMEOUT_EN defined: watchdog built as above.
- Undefined: no counter; timeout_err tied 0 (port retained); partial frame waits indefinitely for further falls; TIMEOUT_CYCLES unused.

## Structure
- ps2_pkg: state enum (IDLE, DATA, PARITY, STOP), frame bit-count constant 8, default parameter values.
- One sub-module: ps2_rx_fifo (FWFT, DEPTH parameter, push/pop/full/empty/level); filter, sync and FSM stay in ps2_receiver.

## Test plan
- Send 0x1C (parity 0, stop 1), FILTER_LEN=4 → ready high exactly 8 cycles after stop-bit fall, data=0x1C, level=1; pop → ready=0, level=0.
- Send 0xF0 with parity bit inverted → parity_err=1, level=0; err_clr pulse → parity_err=0.
- Send 0x5A with stop=0 → frame_err=1, parity_err=0, no push.
- FIFO_DEPTH=8: send 9 bytes 0x01..0x09 without popping → level=8, overflow=1; pops return 0x01..0x08 in order.
- 1-cycle-wide glitch pulses on ps2_clk → no state change, no errors; 0x12 sent afterwards received intact.
- With PS2_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: start bit + 3 data bits, then idle → timeout_err=1 at cycle 100 after last fall; next full frame 0x34 received correctly.
